// File: rtl/eth_sma_pkg.sv
// eth_sma_pkg: shared constants, FSM encoding and default reset image for the Clause-22 SMA slave
// Contents: field widths, OP/ST codes, state constants, ramp_image() (register i resets to i)
package eth_sma_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 5;
    localparam int MAX_REGS = 32;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] ST_BITS  = 2'b01;
    typedef logic [3:0] state_t;
    localparam state_t S_PRE   = 4'd0;
    localparam state_t S_ST    = 4'd1;
    localparam state_t S_OP    = 4'd2;
    localparam state_t S_PHYAD = 4'd3;
    localparam state_t S_REGAD = 4'd4;
    localparam state_t S_TA    = 4'd5;
    localparam state_t S_WDATA = 4'd6;
    localparam state_t S_RDATA = 4'd7;
    localparam state_t S_DONE  = 4'd8;
    function automatic logic [MAX_REGS*DATA_W-1:0] ramp_image();
        logic [MAX_REGS*DATA_W-1:0] r;
        for (int i = 0; i < MAX_REGS; i++) r[i*DATA_W +: DATA_W] = DATA_W'(i);
        return r;
    endfunction
endpackage

// File: rtl/eth_sma_sync_edge.sv
// eth_sma_sync_edge: STAGES-deep synchronizer with rise/fall pulses on edge_in; din rides the same chain
// Ports: clk, rst (async, active-high), edge_in (MDC), din (MDIO), dout (synchronized din),
//        rise/fall (one-clk pulses on synchronized edge_in)
module eth_sma_sync_edge #(
    parameter int STAGES = 2,
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         edge_in,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         rise,
    output logic         fall
);
    logic [STAGES-1:0][W:0] sr;
    logic prev;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sr <= '0;
            prev <= 1'b0;
        end else begin
            sr[0] <= {din, edge_in};
            for (int k = 1; k < STAGES; k++) sr[k] <= sr[k-1];
            prev <= sr[STAGES-1][0];
        end
    assign dout = sr[STAGES-1][W:1];
    assign rise = sr[STAGES-1][0] & ~prev;
    assign fall = ~sr[STAGES-1][0] & prev;
endmodule

// File: rtl/eth_phy_sma_slave.sv
// eth_phy_sma_slave: synthesizable Clause-22 MDIO/SMA PHY management slave with local register port
// Ports: clk, rst (async, active-high); eth_mdc, eth_mdio_i/o/oe (pad side);
//        loc_addr/loc_wr/loc_wdata/loc_rdata (on-chip access); mdio_wr_vld/addr/data (write notify); busy
// Option: ETH_SMA_PREAMBLE_SUPPRESS_EN lets a frame following a completed frame start after one idle 1
module eth_phy_sma_slave
    import eth_sma_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter logic [ADDR_W-1:0] PHY_ADDRESS = 5'd1,
    parameter int PREAMBLE_BITS = 32,
    parameter int SYNC_STAGES = 2,
    parameter logic [NUM_REGS*DATA_W-1:0] REG_RST_VALUE = (NUM_REGS*DATA_W)'(ramp_image()),
    parameter logic [NUM_REGS-1:0] RO_MASK = NUM_REGS'(8'h0C)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              eth_mdc,
    input  logic              eth_mdio_i,
    output logic              eth_mdio_o,
    output logic              eth_mdio_oe,
    input  logic [ADDR_W-1:0] loc_addr,
    input  logic              loc_wr,
    input  logic [DATA_W-1:0] loc_wdata,
    output logic [DATA_W-1:0] loc_rdata,
    output logic              mdio_wr_vld,
    output logic [ADDR_W-1:0] mdio_wr_addr,
    output logic [DATA_W-1:0] mdio_wr_data,
    output logic              busy
);
    localparam int PW = $clog2(PREAMBLE_BITS + 1);
    localparam logic [PW-1:0] PMAX = PW'(PREAMBLE_BITS);
    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    state_t state;
    logic [PW-1:0] pre_cnt;
    logic [3:0] bit_cnt;
    logic mdio_s, mdc_rise, mdc_fall, op_rd, op_ok, match, pre_ok, wr_ok, commit, drive;
    logic [ADDR_W-1:0] phyad, regad, ra_next;
    logic [DATA_W-1:0] sh, rd_val, wd_next;

    eth_sma_sync_edge #(.STAGES(SYNC_STAGES), .W(1)) u_sync (
        .clk(clk), .rst(rst), .edge_in(eth_mdc), .din(eth_mdio_i),
        .dout(mdio_s), .rise(mdc_rise), .fall(mdc_fall)
    );

    assign ra_next = {regad[ADDR_W-2:0], mdio_s};
    assign wd_next = {sh[DATA_W-2:0], mdio_s};
    // op_rd holds the first OP bit while the second is being sampled
    assign op_ok = {op_rd, mdio_s} == OP_READ || {op_rd, mdio_s} == OP_WRITE;
    // drive starts on the fall before the second TA bit and covers all 16 data falls
    assign drive = op_rd && match && (state == S_RDATA || (state == S_TA && bit_cnt == 4'd1));
    assign commit = mdc_rise && state == S_WDATA && bit_cnt == 4'hF && match && wr_ok;
    assign busy = state != S_PRE;

    always_comb begin
        rd_val = '0;
        loc_rdata = '0;
        wr_ok = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_val = ra_next == ADDR_W'(i) ? regs[i] : rd_val;
            loc_rdata = loc_addr == ADDR_W'(i) ? regs[i] : loc_rdata;
            wr_ok = regad == ADDR_W'(i) ? !RO_MASK[i] : wr_ok;
        end
    end

`ifdef ETH_SMA_PREAMBLE_SUPPRESS_EN
    logic armed, abort;
    assign abort = mdc_rise && ((state == S_ST && mdio_s != ST_BITS[0]) ||
                                (state == S_OP && bit_cnt[0] && !op_ok));
    always_ff @(posedge clk or posedge rst)
        if (rst) armed <= 1'b0;
        else armed <= state == S_DONE ? 1'b1 : (abort ? 1'b0 : armed);
    assign pre_ok = pre_cnt == PMAX || (armed && pre_cnt != '0);
`else
    assign pre_ok = pre_cnt == PMAX;
`endif

    // MDIO commit is ordered after the local write so it wins on the same register
    always_ff @(posedge clk or posedge rst)
        if (rst) regs <= REG_RST_VALUE;
        else
            for (int i = 0; i < NUM_REGS; i++) begin
                if (loc_wr && loc_addr == ADDR_W'(i)) regs[i] <= loc_wdata;
                if (commit && regad == ADDR_W'(i)) regs[i] <= wd_next;
            end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= S_PRE;
            pre_cnt <= '0;
            bit_cnt <= '0;
            op_rd <= 1'b0;
            match <= 1'b0;
            phyad <= '0;
            regad <= '0;
            sh <= '0;
            eth_mdio_o <= 1'b0;
            eth_mdio_oe <= 1'b0;
            mdio_wr_vld <= 1'b0;
            mdio_wr_addr <= '0;
            mdio_wr_data <= '0;
        end else begin
            mdio_wr_vld <= commit;
            if (commit) begin
                mdio_wr_addr <= regad;
                mdio_wr_data <= wd_next;
            end
            if (mdc_fall) begin
                eth_mdio_oe <= drive;
                eth_mdio_o <= drive && state == S_RDATA && sh[4'hF - bit_cnt];
            end
            if (state == S_DONE) begin
                state <= S_PRE;
                pre_cnt <= '0;
            end else if (mdc_rise) begin
                case (state)
                    S_PRE: begin
                        pre_cnt <= mdio_s ? (pre_cnt == PMAX ? pre_cnt : pre_cnt + PW'(1)) : '0;
                        if (mdio_s == ST_BITS[1] && pre_ok) state <= S_ST;
                    end
                    S_ST: begin
                        bit_cnt <= '0;
                        state <= mdio_s == ST_BITS[0] ? S_OP : S_PRE;
                    end
                    S_OP: begin
                        op_rd <= bit_cnt[0] ? op_rd : mdio_s;
                        bit_cnt <= bit_cnt[0] ? 4'd0 : 4'd1;
                        if (bit_cnt[0]) state <= op_ok ? S_PHYAD : S_PRE;
                    end
                    S_PHYAD: begin
                        phyad <= {phyad[ADDR_W-2:0], mdio_s};
                        bit_cnt <= bit_cnt == 4'd4 ? 4'd0 : bit_cnt + 4'd1;
                        if (bit_cnt == 4'd4) state <= S_REGAD;
                    end
                    S_REGAD: begin
                        regad <= ra_next;
                        bit_cnt <= bit_cnt == 4'd4 ? 4'd0 : bit_cnt + 4'd1;
                        if (bit_cnt == 4'd4) begin
                            state <= S_TA;
                            match <= phyad == PHY_ADDRESS;
                            sh <= rd_val;
                        end
                    end
                    S_TA: begin
                        bit_cnt <= bit_cnt[0] ? 4'd0 : 4'd1;
                        if (bit_cnt[0]) state <= op_rd ? S_RDATA : S_WDATA;
                    end
                    S_WDATA, S_RDATA: begin
                        sh <= state == S_WDATA ? wd_next : sh;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'hF) state <= S_DONE;
                    end
                    default: begin
                        state <= S_PRE;
                        pre_cnt <= '0;
                        bit_cnt <= '0;
                    end
                endcase
            end
        end
endmodule

// File: tb/tb_eth_phy_sma_slave.sv
// tb_eth_phy_sma_slave: directed MDIO frames against eth_phy_sma_slave with write/read scoreboards
module tb_eth_phy_sma_slave;
    logic clk = 1'b0, rst = 1'b1, eth_mdc = 1'b0, eth_mdio_i = 1'b1, loc_wr = 1'b0;
    logic eth_mdio_o, eth_mdio_oe, mdio_wr_vld, busy;
    logic [4:0] loc_addr = 5'd0, mdio_wr_addr;
    logic [15:0] loc_wdata = 16'd0, loc_rdata, mdio_wr_data;
    int tests = 0, fails = 0, vld_cnt = 0, oe_cnt = 0, v0, o0;
    logic [20:0] exp_wr[$];
    logic [15:0] exp_rd[$];
    logic [15:0] mdl[0:7];
    logic [15:0] r_rd;
    logic [1:0] r_ta_oe;
    logic r_ta_o, r_all, r_busy_mid, r_oe_end, r_busy_end;

    eth_phy_sma_slave dut (
        .clk(clk), .rst(rst), .eth_mdc(eth_mdc), .eth_mdio_i(eth_mdio_i),
        .eth_mdio_o(eth_mdio_o), .eth_mdio_oe(eth_mdio_oe),
        .loc_addr(loc_addr), .loc_wr(loc_wr), .loc_wdata(loc_wdata), .loc_rdata(loc_rdata),
        .mdio_wr_vld(mdio_wr_vld), .mdio_wr_addr(mdio_wr_addr), .mdio_wr_data(mdio_wr_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (eth_mdio_oe) oe_cnt++;
        if (mdio_wr_vld) begin
            vld_cnt++;
            check("wr_unexpected", exp_wr.size() != 0, 1);
            if (exp_wr.size() != 0) check("wr_pulse", {mdio_wr_addr, mdio_wr_data}, exp_wr.pop_front());
        end
    end

    task automatic peek(input logic [4:0] a, input logic [15:0] exp, input string tag);
        loc_addr = a;
        #1;
        check(tag, loc_rdata, exp);
    endtask

    task automatic mbit(input logic b, input logic do_loc, output logic ob, output logic oe_s);
        eth_mdio_i = b;
        repeat (8) @(negedge clk);
        ob = eth_mdio_o;
        oe_s = eth_mdio_oe;
        eth_mdc = 1'b1;
        if (do_loc) begin
            @(negedge clk);
            loc_wr = 1'b1;
            repeat (2) @(negedge clk);
            loc_wr = 1'b0;
            repeat (5) @(negedge clk);
        end else repeat (8) @(negedge clk);
        eth_mdc = 1'b0;
    endtask

    task automatic frame(input int npre, input logic [1:0] op, input logic [4:0] pa, input logic [4:0] ra,
                         input logic [15:0] wd, input logic coll, input int ndata);
        logic ob, oe;
        logic [13:0] hdr;
        logic [1:0] ta;
        hdr = {2'b01, op, pa, ra};
        ta = op == 2'b01 ? 2'b10 : 2'b11;
        r_rd = '0;
        r_all = 1'b1;
        for (int i = 0; i < npre; i++) mbit(1'b1, 1'b0, ob, oe);
        for (int i = 13; i >= 0; i--) mbit(hdr[i], 1'b0, ob, oe);
        r_busy_mid = busy;
        for (int i = 1; i >= 0; i--) begin
            mbit(ta[i], 1'b0, ob, oe);
            r_ta_oe[i] = oe;
            r_ta_o = ob;
        end
        for (int i = 15; i >= 16 - ndata; i--) begin
            mbit(op == 2'b01 ? wd[i] : 1'b1, coll && i == 0, ob, oe);
            r_rd[i] = ob;
            r_all &= oe;
        end
        if (ndata == 16) begin
            repeat (8) @(negedge clk);
            r_oe_end = eth_mdio_oe;
            r_busy_end = busy;
        end
    endtask

    initial begin
        logic ob, oe;
        for (int i = 0; i < 8; i++) mdl[i] = 16'(i);
        repeat (3) @(negedge clk);
        check("rst_oe", eth_mdio_oe, 0);
        check("rst_o", eth_mdio_o, 0);
        check("rst_vld", mdio_wr_vld, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) peek(5'(i), mdl[i], "rst_reg");
        peek(5'd9, 16'h0000, "rst_oor");

        // write reg0
        exp_wr.push_back({5'd0, 16'hA5C3});
        mdl[0] = 16'hA5C3;
        o0 = oe_cnt;
        frame(32, 2'b01, 5'd1, 5'd0, 16'hA5C3, 1'b0, 16);
        check("w0_oe", oe_cnt - o0, 0);
        check("w0_busy_end", r_busy_end, 0);
        check("w0_pending", exp_wr.size(), 0);
        peek(5'd0, mdl[0], "w0_reg");

        // read reg4
        exp_rd.push_back(mdl[4]);
        frame(32, 2'b10, 5'd1, 5'd4, 16'h0, 1'b0, 16);
        check("r4_ta_oe", r_ta_oe, 2'b01);
        check("r4_ta_o", r_ta_o, 0);
        check("r4_data", r_rd, exp_rd.pop_front());
        check("r4_oe_all", r_all, 1);
        check("r4_oe_end", r_oe_end, 0);
        check("r4_busy_mid", r_busy_mid, 1);
        check("r4_busy_end", r_busy_end, 0);

        // read with foreign PHY address
        o0 = oe_cnt;
        frame(32, 2'b10, 5'd3, 5'd4, 16'h0, 1'b0, 16);
        check("r_mis_oe", oe_cnt - o0, 0);
        check("r_mis_busy_mid", r_busy_mid, 1);
        check("r_mis_busy_end", r_busy_end, 0);

        // read-only write with simultaneous local write to another register
        v0 = vld_cnt;
        loc_addr = 5'd5;
        loc_wdata = 16'h1234;
        mdl[5] = 16'h1234;
        frame(32, 2'b01, 5'd1, 5'd2, 16'hFFFF, 1'b1, 16);
        check("ro_vld", vld_cnt - v0, 0);
        peek(5'd2, mdl[2], "ro_reg2");
        peek(5'd5, mdl[5], "loc_reg5");

        // same-register collision, MDIO wins
        loc_addr = 5'd6;
        loc_wdata = 16'h1111;
        exp_wr.push_back({5'd6, 16'hBEEF});
        mdl[6] = 16'hBEEF;
        frame(32, 2'b01, 5'd1, 5'd6, 16'hBEEF, 1'b1, 16);
        peek(5'd6, mdl[6], "coll_reg6");

        // OP=11 abort
        v0 = vld_cnt;
        o0 = oe_cnt;
        frame(32, 2'b11, 5'd1, 5'd1, 16'h0, 1'b0, 16);
        check("op11_oe", oe_cnt - o0, 0);
        check("op11_busy", r_busy_end, 0);
        check("op11_vld", vld_cnt - v0, 0);
        mbit(1'b0, 1'b0, ob, oe);

        // 31-bit preamble is not enough
        frame(31, 2'b01, 5'd1, 5'd1, 16'h0F0F, 1'b0, 16);
        check("pre31_vld", vld_cnt - v0, 0);
        check("pre31_busy", r_busy_end, 0);
        peek(5'd1, mdl[1], "pre31_reg1");

        // next valid write succeeds
        exp_wr.push_back({5'd1, 16'h1357});
        mdl[1] = 16'h1357;
        frame(32, 2'b01, 5'd1, 5'd1, 16'h1357, 1'b0, 16);
        peek(5'd1, mdl[1], "w1_reg");

        // out-of-range read returns zero
        exp_rd.push_back(16'h0000);
        frame(32, 2'b10, 5'd1, 5'd9, 16'h0, 1'b0, 16);
        check("oor_ta_oe", r_ta_oe, 2'b01);
        check("oor_data", r_rd, exp_rd.pop_front());

        // reset in the middle of RDATA
        frame(32, 2'b10, 5'd1, 5'd4, 16'h0, 1'b0, 5);
        check("mid_oe_before", eth_mdio_oe, 1);
        #3 rst = 1'b1;
        #1 check("mid_oe_async", eth_mdio_oe, 0);
        check("mid_busy", busy, 0);
        for (int i = 0; i < 8; i++) mdl[i] = 16'(i);
        peek(5'd0, mdl[0], "mid_reg0");
        peek(5'd5, mdl[5], "mid_reg5");
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        exp_rd.push_back(mdl[4]);
        frame(32, 2'b10, 5'd1, 5'd4, 16'h0, 1'b0, 16);
        check("post_ta_oe", r_ta_oe, 2'b01);
        check("post_data", r_rd, exp_rd.pop_front());
        check("post_oe_end", r_oe_end, 0);
        exp_wr.push_back({5'd0, 16'h5A5A});
        mdl[0] = 16'h5A5A;
        frame(32, 2'b01, 5'd1, 5'd0, 16'h5A5A, 1'b0, 16);
        peek(5'd0, mdl[0], "post_w0");

        repeat (4) @(negedge clk);
        check("wr_queue_empty", exp_wr.size(), 0);
        check("vld_total", vld_cnt, 4);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/eth_phy_sma_slave.md
Name: eth_phy_sma_slave

Overview:
- Synthesizable Clause-22 MDIO/SMA PHY management slave; successor to the behavioural PHY SMA model.
- Register file depth, PHY address, reset values and read-only mask are parameters.
- Oversamples MDC/MDIO in the system clock domain. Drives MDIO through split i/o/oe pins for the pad ring.
- Local port gives on-chip logic register access and write notification. Used in the FPGA PHY-emulation top and as a synthesizable bench slave.

Parameters:
- NUM_REGS, 8: number of 16-bit registers, 1..32.
- PHY_ADDRESS, 1: 5-bit address this slave answers to.
- PREAMBLE_BITS, 32: consecutive sampled 1s required before ST.
- SYNC_STAGES, 2: synchronizer depth for MDC and MDIO.
- REG_RST_VALUE, register i = i: packed NUM_REGS*16 reset values; register i is in bits [16i+15:16i].
- RO_MASK, 8'h0C: bit i=1 makes register i read-only from MDIO.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- eth_mdc  in  1  management clock from MAC.
- eth_mdio_i  in  1  MDIO pad input.
- eth_mdio_o  out  1  MDIO pad output value.
- eth_mdio_oe  out  1  MDIO output enable, 1 = drive.
- loc_addr  in  5  local access address.
- loc_wr  in  1  local write strobe (ignores RO_MASK).
- loc_wdata  in  16  local write data.
- loc_rdata  out  16  combinational read of reg[loc_addr]; 0 if out of range.
- mdio_wr_vld  out  1  one-clk pulse on committed MDIO write.
- mdio_wr_addr  out  5  register address of that write.
- mdio_wr_data  out  16  data of that write.
- busy  out  1  high from ST detect until frame end or abort.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-high. On reset: oe=0, o=0, mdio_wr_vld=0, busy=0, FSM=PRE, preamble count=0, registers=REG_RST_VALUE.
- Synchronization: MDC and MDIO pass through identical SYNC_STAGES synchronizers.
- Sampling: on a detected MDC rise, take the synchronized MDIO as one bit.
- Driving: on a detected MDC fall, update eth_mdio_o/oe in the following clk.
- Timing requirement: MDC high and low each ≥ SYNC_STAGES+2 clk.
- Bit order: MSB first in all fields.
- FSM states: PRE, ST, OP, PHYAD, REGAD, TA, WDATA, RDATA, DONE.
  - PRE: a sampled 1 increments the count (saturating); a sampled 0 clears it. A 0 sampled with count ≥ PREAMBLE_BITS goes to ST (first ST bit seen).
  - ST: expects 1. A 0 aborts to PRE with count=0.
  - OP: 01 = write, 10 = read. 00 or 11 aborts to PRE.
  - PHYAD (5 bits) then REGAD (5 bits). Match = (PHYAD == PHY_ADDRESS).
  - TA, write: two bits sampled and ignored; oe stays 0.
  - TA, read with match: first TA bit oe=0. On the fall before the second TA bit: oe=1, o=0.
  - TA, read with mismatch: oe stays 0 for the whole frame (no drive, no NACK). The FSM still counts 16 data bits.
  - RDATA: data is latched at the end of REGAD. On each of 16 falls, drive the next bit. Release oe on the fall after bit 0. Out-of-range register reads return 16'h0000.
  - WDATA: 16 bits sampled. After the 16th rise, commit if match, in range and not RO: register updates and mdio_wr_vld pulses for one clk. Otherwise no update and no pulse.
  - DONE: one clk, then PRE with count=0.
- Collisions: loc_wr and an MDIO commit to the same register in the same clk: MDIO wins. Different registers: both apply.
- Register view: loc_rdata reflects the updated register the clk after a commit.
- Reset mid-frame: immediate return to reset state, oe drops asynchronously.
- MDC stopped: FSM holds indefinitely, no timeout.

Optional Feature:
- ETH_SMA_PREAMBLE_SUPPRESS_EN.
- Defined: after a frame ends in DONE (not an abort), PRE accepts ST once it has sampled ≥1 idle 1 bit. Any abort or reset re-arms the full PREAMBLE_BITS requirement.
- Undefined: every frame needs PREAMBLE_BITS ones.

Decomposition:
- Package eth_sma_pkg: state enum, OP_WRITE=2'b01, OP_READ=2'b10, ST_BITS=2'b01, DATA_W=16, ADDR_W=5.
- Sub-module eth_sma_sync_edge: SYNC_STAGES synchronizer plus rise/fall pulse detect. Instantiated for MDC; its synchronized data path is reused for MDIO.

Test Plan:
- Write reg 0 to 16'hA5C3 after 32 preamble ones, PHYAD=1 -> reg0=A5C3; mdio_wr_vld one pulse, addr 0, data A5C3; oe never 1.
- Read reg 4 after reset -> oe rises on second TA bit with o=0; serial 16'h0004 MSB first; oe=0 after the last fall.
- Read with PHYAD=3 -> oe stays 0 for the whole frame; busy drops after DONE.
- Write reg 2 (RO) 16'hFFFF -> reg2 stays 0002; no mdio_wr_vld; same-clk loc_wr to reg5 with 1234 -> reg5=1234.
- 31-bit preamble, or OP=11 -> no response, FSM back in PRE; the next valid write succeeds.
- Assert rst mid RDATA -> oe=0 within the same clk; registers back to reset values; next frame decodes normally.
